// File: rtl/lsu_burst_seq.sv
// rtl/lsu_burst_seq.sv - multi-beat load/store sequencer between decode/register file and data SRAM
// Optional feature macro: LSU_BURST_ALIGN_CHECK_EN (address/register-pair alignment checking)
module lsu_burst_seq #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4,
  parameter int BW        = $clog2(MAX_BEATS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BW-1:0]     req_beats,
  input  logic [31:0]       req_addr,
  input  logic [4:0]        req_reg,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

  state_t            state;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beats_r;
  logic [ADDR_W-1:0] base_w;
  logic [4:0]        base_reg;
  logic              write_r;
  logic              done_r;
  logic              err_r;

  logic              accept;
  logic [BW-1:0]     eff_beats;
  logic              req_err;
  logic [4:0]        cur_reg;

  // The done cycle keeps req_ready low so the still-held request is not taken twice
  assign req_ready = (state == IDLE) && !done_r;
  assign accept    = req_valid && req_ready;
  assign stall     = (state != IDLE) || accept;
  assign done      = done_r || (state == DRAIN);
  assign err       = err_r;
  assign cur_reg   = base_reg + 5'(beat_cnt);

  // Zero beats means one; anything above MAX_BEATS is clamped
  always_comb begin
    eff_beats = req_beats;
    if (req_beats == '0)
      eff_beats = BW'(1);
    else if (req_beats > BW'(MAX_BEATS))
      eff_beats = BW'(MAX_BEATS);
  end

`ifdef LSU_BURST_ALIGN_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  // Misaligned byte address, or a double-word pair starting on an odd register
  assign req_err = (req_addr[1:0] != 2'b00) || ((eff_beats == BW'(2)) && req_reg[0]);
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign req_err = 1'b0;
`endif

  // Burst sequencing: capture request, step one beat per cycle, drain the last load word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      beats_r  <= '0;
      base_w   <= '0;
      base_reg <= '0;
      write_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (accept) begin
            beats_r  <= eff_beats;
            base_w   <= req_addr[ADDR_W+1:2];
            base_reg <= req_reg;
            write_r  <= req_write;
            beat_cnt <= '0;
            if (req_err) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // beat_cnt ends at beats_r so DRAIN addresses the last register as cur_reg-1
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == beats_r - 1'b1) begin
            if (write_r) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM and register-file strobes decoded from the current beat; loads write back one beat late
  always_comb begin
    CEN      = 1'b1;
    WEN      = 1'b1;
    OEN      = 1'b1;
    A        = '0;
    Data2Mem = '0;
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      ACCESS: begin
        CEN = 1'b0;
        A   = base_w + ADDR_W'(beat_cnt);
        if (write_r) begin
          WEN      = 1'b0;
          rf_raddr = cur_reg;
          Data2Mem = rf_rdata;
        end else begin
          OEN = 1'b0;
          if (beat_cnt != '0) begin
            rf_we    = 1'b1;
            rf_waddr = cur_reg - 5'd1;
            rf_wdata = ReadDataMem;
          end
        end
      end
      DRAIN: begin
        rf_we    = 1'b1;
        rf_waddr = cur_reg - 5'd1;
        rf_wdata = ReadDataMem;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_burst_seq.sv
// tb/tb_lsu_burst_seq.sv - randomized self-checking bench for lsu_burst_seq
module tb_lsu_burst_seq;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int MAXB   = 4;
  localparam int BW     = $clog2(MAXB) + 1;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [BW-1:0]     req_beats;
  logic [31:0]       req_addr;
  logic [4:0]        req_reg;
  logic              stall;
  logic              done;
  logic              err;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;

  lsu_burst_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_beats(req_beats), .req_addr(req_addr), .req_reg(req_reg),
    .stall(stall), .done(done), .err(err),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous single-port SRAM and register file
  logic [DATA_W-1:0] mem     [NWORDS];
  logic [DATA_W-1:0] rf      [32];
  logic [DATA_W-1:0] init_mem[NWORDS];
  logic [DATA_W-1:0] init_rf [32];
  logic [DATA_W-1:0] rdm;
  logic              load_init;

  assign rf_rdata    = rf[rf_raddr];
  assign ReadDataMem = rdm;

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_mem[i];
      for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
      rdm <= '0;
    end else begin
      if (!CEN && !WEN) mem[A] <= Data2Mem;
      if (!CEN && !OEN) rdm <= mem[A];
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

  // Reference images of memory and register file
  logic [DATA_W-1:0] ref_mem[NWORDS];
  logic [DATA_W-1:0] ref_rf [32];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic compare_images(input string tag);
    int bad_m;
    int bad_r;
    bad_m = 0;
    bad_r = 0;
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== ref_mem[i]) bad_m++;
    for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) bad_r++;
    check({tag, "_mem_img"}, bad_m, 0);
    check({tag, "_rf_img"}, bad_r, 0);
  endtask

  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic [31:0] qw[$];
  int          qwc[$];

  // One request held through its done cycle; checked against the reference rules
  task automatic do_req(input string tag, input logic wr, input int beats,
                        input logic [31:0] addr, input int rg);
    int eff, w, done_cyc, bad_stall;
    logic exp_err, err_seen, ready_at_done, stall_at_done;
    eff = (beats == 0) ? 1 : ((beats > MAXB) ? MAXB : beats);
    w   = int'((addr >> 2) % NWORDS);
    exp_err = 1'b0;
`ifdef LSU_BURST_ALIGN_CHECK_EN
    if ((addr % 4) != 0 || (eff == 2 && (rg % 2) == 1)) exp_err = 1'b1;
`endif
    qa.delete();
    qd.delete();
    qw.delete();
    qwc.delete();
    req_write = wr;
    req_beats = BW'(beats);
    req_addr  = addr;
    req_reg   = 5'(rg);
    req_valid = 1'b1;
    #1;
    check({tag, "_ready_c0"}, req_ready, 1);
    check({tag, "_stall_c0"}, stall, 1);
    done_cyc = 0;
    bad_stall = 0;
    err_seen = 1'b0;
    ready_at_done = 1'b1;
    stall_at_done = 1'b1;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      step();
      if (!CEN) begin
        qa.push_back(32'(A));
        if (!WEN) qd.push_back(Data2Mem);
      end
      if (rf_we) begin
        qw.push_back(32'(rf_waddr));
        qwc.push_back(c);
      end
      if (done) begin
        done_cyc      = c;
        err_seen      = err;
        ready_at_done = req_ready;
        stall_at_done = stall;
      end else if (stall !== 1'b1) begin
        bad_stall++;
      end
    end
    req_valid = 1'b0;
    if (done_cyc == 0) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_done_cycle"}, done_cyc, exp_err ? 1 : eff + 1);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_ready_at_done"}, ready_at_done, 0);
    check({tag, "_stall_at_done"}, stall_at_done, (!exp_err && !wr) ? 1 : 0);
    check({tag, "_stall_busy"}, bad_stall, 0);
    check({tag, "_beats"}, qa.size(), exp_err ? 0 : eff);
    if (!exp_err) begin
      for (int k = 0; k < eff && k < qa.size(); k++)
        check({tag, "_addr"}, qa[k], (w + k) % NWORDS);
      if (wr) begin
        check({tag, "_wr_beats"}, qd.size(), eff);
        for (int k = 0; k < eff && k < qd.size(); k++)
          check({tag, "_wdata"}, qd[k], ref_rf[(rg + k) % 32]);
        for (int k = 0; k < eff; k++) ref_mem[(w + k) % NWORDS] = ref_rf[(rg + k) % 32];
      end else begin
        check({tag, "_rf_writes"}, qw.size(), eff);
        for (int k = 0; k < eff && k < qw.size(); k++) begin
          check({tag, "_waddr"}, qw[k], (rg + k) % 32);
          check({tag, "_wcycle"}, qwc[k], k + 2);
        end
        for (int k = 0; k < eff; k++) ref_rf[(rg + k) % 32] = ref_mem[(w + k) % NWORDS];
      end
    end
    step();
    check({tag, "_ready_next"}, req_ready, 1);
    check({tag, "_stall_next"}, stall, 0);
    compare_images(tag);
  endtask

  initial begin
    logic wr;
    int beats;
    int rg;
    logic [31:0] addr;

    rst_n     = 1'b0;
    load_init = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_beats = '0;
    req_addr  = '0;
    req_reg   = '0;
    for (int i = 0; i < NWORDS; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    for (int i = 0; i < 32; i++) init_rf[i] = $urandom;
    init_rf[4] = 32'hDEADBEEF;
    init_rf[5] = 32'h12345678;
    for (int i = 0; i < 32; i++) ref_rf[i] = init_rf[i];

    step();
    step();
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_oen", OEN, 1);
    check("rst_a", 32'(A), 0);
    check("rst_ready", req_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rfwe", rf_we, 0);
    load_init = 1'b0;
    rst_n = 1'b1;
    step();

    do_req("st2", 1'b1, 2, 32'h40, 4);
    check("st2_a0", qa.size() > 0 ? qa[0] : 32'hFFFF_FFFF, 32'h10);
    check("st2_d0", qd.size() > 0 ? qd[0] : 32'h0, 32'hDEADBEEF);
    check("st2_d1", qd.size() > 1 ? qd[1] : 32'h0, 32'h12345678);

    do_req("ld4wrap", 1'b0, 4, 32'h1F8, 30);
    check("ld4wrap_a2", qa.size() > 2 ? qa[2] : 32'hFFFF_FFFF, 32'h00);
    check("ld4wrap_w2", qw.size() > 2 ? qw[2] : 32'hFFFF_FFFF, 32'h00);

    do_req("mis42", 1'b0, 1, 32'h42, 6);
    do_req("oddpair", 1'b1, 2, 32'h20, 3);
    do_req("beats0", 1'b0, 0, 32'h88, 10);
    do_req("beats7", 1'b1, 7, 32'h100, 12);

    // Reset in the middle of a load: the first read never reaches the register file
    req_write = 1'b0;
    req_beats = BW'(4);
    req_addr  = 32'h30;
    req_reg   = 5'd8;
    req_valid = 1'b1;
    step();
    step();
    check("rstmid_busy", CEN, 0);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rstmid_cen", CEN, 1);
    check("rstmid_oen", OEN, 1);
    check("rstmid_rfwe", rf_we, 0);
    check("rstmid_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rstmid_ready", req_ready, 1);
    check("rstmid_stall", stall, 0);
    compare_images("rstmid");

    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      beats = int'($urandom_range(0, 7));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      rg    = int'($urandom_range(0, 31));
      do_req("rnd", wr, beats, addr, rg);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_burst_seq.md
# lsu_burst_seq

Parametrised multi-beat load/store sequencer between the MIPS core's decode/register-file stage and the single-port data SRAM (CEN/WEN/OEN/A/Data2Mem/ReadDataMem). It generalises the two-cycle double-word stall used for ldc1/sdc1 to bursts of 1..MAX_BEATS consecutive words. Each burst moves data to or from consecutive register-file entries, and the block holds the core with `stall` until the burst completes. It adds explicit handshaking, synchronous-SRAM read latency, address/register wrap rules, and optional alignment checking.

## Interface
- `ADDR_W`, 7: SRAM word-address width (`A` width).
- `DATA_W`, 32: data width.
- `MAX_BEATS`, 4: maximum words per burst, ≥1.
- `BW`, `$clog2(MAX_BEATS)+1`: width of `req_beats`.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present; held by the core while stalled.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store (reg→mem), 0 = load (mem→reg).
- `req_beats`  in  BW  word count.
- `req_addr`  in  32  byte address of first word.
- `req_reg`  in  5  first register index.
- `stall`  out  1  core must hold PC/instruction.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle misalignment pulse, coincident with `done`.
- `rf_raddr`  out  5  register-file read index (stores).
- `rf_rdata`  in  DATA_W  combinational read data for `rf_raddr`.
- `rf_we`  out  1  register-file write enable (loads).
- `rf_waddr`  out  5  register write index.
- `rf_wdata`  out  DATA_W  register write data.
- `CEN`  out  1  SRAM chip enable, active-low.
- `WEN`  out  1  SRAM write enable, active-low.
- `OEN`  out  1  SRAM output enable, active-low.
- `A`  out  ADDR_W  SRAM word address.
- `Data2Mem`  out  DATA_W  SRAM write data.
- `ReadDataMem`  in  DATA_W  SRAM read data, valid one cycle after a read beat.

## Operation
- **States:** IDLE, ACCESS, DRAIN. Registers: `beat_cnt`, `beats_r`, `base_w` (ADDR_W), `base_reg` (5), `write_r`, `done_r`, `err_r`.
- **Beat count:** `req_beats` = 0 is treated as 1; `req_beats` > MAX_BEATS is clamped to MAX_BEATS.
- **Word address:** `req_addr[ADDR_W+1:2]`.
- **IDLE:**
  - `req_ready` = !`done_r`.
  - On `req_valid & req_ready`, capture the request, then:
    - if an error is detected: stay in IDLE and set `done_r` = `err_r` = 1;
    - otherwise go to ACCESS with `beat_cnt` = 0.
- **ACCESS:** one beat per cycle, with k = `beat_cnt`.
  - `A` = `base_w` + k, modulo 2^ADDR_W (wraps).
  - Register index = `base_reg` + k, modulo 32 (wraps, including through r0).
  - Store beat: `CEN`=0, `WEN`=0, `OEN`=1, `rf_raddr` = index, `Data2Mem` = `rf_rdata`.
  - Load beat: `CEN`=0, `OEN`=0, `WEN`=1. The data for beat k-1 is written to the register file this cycle: `rf_we`=1, `rf_waddr` = index-1, `rf_wdata` = `ReadDataMem`.
  - After the last beat: a store goes to IDLE and sets `done_r`; a load goes to DRAIN.
- **DRAIN:** `CEN`=`OEN`=`WEN`=1; writes the last load word to the register file; `done` = 1; goes to IDLE.
- **Outputs:**
  - `done` = `done_r` | (state == DRAIN).
  - `err` = `err_r`.
  - `stall` = (state ≠ IDLE) | (`req_valid` & `req_ready`).
- **Reset** (asynchronous, effective mid-burst):
  - State goes to IDLE immediately; all registers clear.
  - Outputs: `CEN`=`WEN`=`OEN`=1, `A`=0, `Data2Mem`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_raddr`=0, `done`=0, `err`=0, `stall`=0, `req_ready`=1.
  - An aborted burst leaves earlier beats committed and later beats not performed.

## Timing
- Request accepted at the edge ending cycle 0; `stall` is high in cycle 0.
- **Store, N beats:** memory beats in cycles 1..N; `done` in cycle N+1, with `stall`=0 and `req_ready`=0. The next request is accepted in cycle N+2 at the earliest.
- **Load, N beats:** read beats in cycles 1..N; register writes in cycles 2..N+1; `done` in cycle N+1 (DRAIN). The next request is accepted in cycle N+2.
- **Error:** `err`=`done`=1 in cycle 1; no SRAM access.
- The `done` cycle always has `req_ready`=0. This prevents re-accepting the held `req_valid` of the completing instruction.
- `rf_rdata` is sampled combinationally in the same cycle as `rf_raddr`.

## Configuration
- **`LSU_BURST_ALIGN_CHECK_EN` defined:** an error is flagged if either condition holds:
  - `req_addr[1:0]` ≠ 0;
  - effective beats = 2 and `req_reg[0]` = 1 (odd double-register pair).
- **Not defined:** `req_addr[1:0]` is ignored, no checks are performed, and `err` is tied to 0.

## Test plan
- **Store 2 beats:** addr 0x40, reg 4, rf[4]=0xDEADBEEF, rf[5]=0x12345678 → cycle 1: `A`=0x10, `WEN`=0, `Data2Mem`=0xDEADBEEF; cycle 2: `A`=0x11, `Data2Mem`=0x12345678; `done` in cycle 3.
- **Load 4 beats with wrap:** addr 0x1F8, reg 30 → `A` = 0x7E, 0x7F, 0x00, 0x01; `rf_waddr` = 30, 31, 0, 1 in cycles 2..5; `done` in cycle 5.
- **Alignment check** (with `LSU_BURST_ALIGN_CHECK_EN`):
  - addr 0x42 → `err`=`done`=1 in cycle 1, `CEN` held at 1;
  - beats 2 with reg 3 → same response.
  - Without the macro, addr 0x42 accesses word 0x10.
- **Beat clamping:** beats 0 → exactly one beat; beats 7 with MAX_BEATS=4 → exactly four beats.
- **Reset mid-load:** assert `rst_n`=0 during beat 2 → `CEN`/`OEN`/`rf_we` deassert the same cycle; after release, `req_ready`=1 and `stall`=0.
- **Held request:** `req_valid` held through `done` → exactly one burst is performed; a new request is accepted in cycle N+2.
